// File: rtl/hit_event_manager_if.sv
// Split-request handshake between the hit event manager (master) and the
// bubble controller (slave): request with hit coordinates, held until acknowledged.
interface hit_event_manager_if;
   logic        splitReq;
   logic        splitAck;
   logic [10:0] splitX;
   logic [10:0] splitY;

   modport master (output splitReq, output splitX, output splitY, input splitAck);
   modport slave  (input splitReq, input splitX, input splitY, output splitAck);
endinterface

// File: rtl/hit_event_manager.sv
// Accumulates per-pixel collision flags over a video frame and commits them at
// startOfFrame: life bookkeeping with invulnerability, arrow retract, split request.
module hit_event_manager #(
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned INVULN_FRAMES = 60
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       startOfFrame,
   input  logic                       bubbleHitChar,
   input  logic                       arrowHitBubble,
   input  logic [10:0]                pixelX,
   input  logic [10:0]                pixelY,
   output logic                       charHitPulse,
   output logic                       arrowReset,
   output logic [2:0]                 livesLeft,
   output logic                       invulnerable,
   output logic                       gameOver,
   hit_event_manager_if.master        split_if
);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } split_state_e;

   localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
   localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);

   split_state_e state_q, state_d;

   logic        char_latch_q,     char_latch_d;
   logic        arrow_latch_q,    arrow_latch_d;
   logic [10:0] hit_x_q,          hit_x_d;
   logic [10:0] hit_y_q,          hit_y_d;
   logic [2:0]  lives_q,          lives_d;
   logic [7:0]  inv_cnt_q,        inv_cnt_d;
   logic        invulnerable_q,   invulnerable_d;
   logic        game_over_q,      game_over_d;
   logic        char_hit_pulse_q, char_hit_pulse_d;
   logic        arrow_reset_q,    arrow_reset_d;
   logic        split_req_q,      split_req_d;
   logic [10:0] split_x_q,        split_x_d;
   logic [10:0] split_y_q,        split_y_d;

   logic char_commit;
   logic arrow_commit;

   // Commits are judged on the latches of the frame that just ended (the _q
   // values); this cycle's flags only seed the new frame's latches.
   assign char_commit  = startOfFrame & char_latch_q & ~invulnerable_q
                       & ~game_over_q & (lives_q != 3'd0);
   assign arrow_commit = startOfFrame & arrow_latch_q & ~game_over_q;

   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d          = state_q;
      char_latch_d     = char_latch_q;
      arrow_latch_d    = arrow_latch_q;
      hit_x_d          = hit_x_q;
      hit_y_d          = hit_y_q;
      lives_d          = lives_q;
      inv_cnt_d        = inv_cnt_q;
      game_over_d      = game_over_q;
      char_hit_pulse_d = 1'b0;
      arrow_reset_d    = 1'b0;
      split_x_d        = split_x_q;
      split_y_d        = split_y_q;

      if (startOfFrame) begin
         char_latch_d  = bubbleHitChar;
         arrow_latch_d = arrowHitBubble;
         hit_x_d       = pixelX;
         hit_y_d       = pixelY;
      end else begin
         char_latch_d = char_latch_q | bubbleHitChar;
         if (arrowHitBubble && !arrow_latch_q) begin
            arrow_latch_d = 1'b1;
            hit_x_d       = pixelX;
            hit_y_d       = pixelY;
         end
      end

      if (char_commit) begin
         lives_d          = lives_q - 3'd1;
         char_hit_pulse_d = 1'b1;
         inv_cnt_d        = INV_LOAD;
         if (lives_q == 3'd1) game_over_d = 1'b1;
      end else if (startOfFrame && inv_cnt_q != 8'd0) begin
         inv_cnt_d = inv_cnt_q - 8'd1;
      end

      // The arrow always retracts on a live commit, even if the split is dropped.
      arrow_reset_d = arrow_commit;

      unique case (state_q)
         IDLE: begin
            if (arrow_commit) begin
               state_d   = REQ;
               split_x_d = hit_x_q;
               split_y_d = hit_y_q;
            end
         end
         REQ: begin
            if (split_if.splitAck) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      split_req_d    = (state_d == REQ);
      invulnerable_d = (inv_cnt_d != 8'd0);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q          <= IDLE;
         char_latch_q     <= 1'b0;
         arrow_latch_q    <= 1'b0;
         hit_x_q          <= '0;
         hit_y_q          <= '0;
         lives_q          <= LIVES_INIT;
         inv_cnt_q        <= '0;
         invulnerable_q   <= 1'b0;
         game_over_q      <= 1'b0;
         char_hit_pulse_q <= 1'b0;
         arrow_reset_q    <= 1'b0;
         split_req_q      <= 1'b0;
         split_x_q        <= '0;
         split_y_q        <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q          <= state_d;
         char_latch_q     <= char_latch_d;
         arrow_latch_q    <= arrow_latch_d;
         hit_x_q          <= hit_x_d;
         hit_y_q          <= hit_y_d;
         lives_q          <= lives_d;
         inv_cnt_q        <= inv_cnt_d;
         invulnerable_q   <= invulnerable_d;
         game_over_q      <= game_over_d;
         char_hit_pulse_q <= char_hit_pulse_d;
         arrow_reset_q    <= arrow_reset_d;
         split_req_q      <= split_req_d;
         split_x_q        <= split_x_d;
         split_y_q        <= split_y_d;
      end
   end

   assign charHitPulse     = char_hit_pulse_q;
   assign arrowReset       = arrow_reset_q;
   assign livesLeft        = lives_q;
   assign invulnerable     = invulnerable_q;
   assign gameOver         = game_over_q;
   assign split_if.splitReq = split_req_q;
   assign split_if.splitX   = split_x_q;
   assign split_if.splitY   = split_y_q;

endmodule

// File: tb/tb_hit_event_manager.sv
// Self-checking bench for hit_event_manager: directed scenarios plus randomized
// stimulus compared every cycle against a frame-level reference model.
module tb_hit_event_manager;

   localparam int START_LIVES   = 3;
   localparam int INVULN_FRAMES = 60;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        bubbleHitChar = 1'b0;
   logic        arrowHitBubble = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        charHitPulse;
   logic        arrowReset;
   logic [2:0]  livesLeft;
   logic        invulnerable;
   logic        gameOver;

   hit_event_manager_if split_if ();

   always #5 clk = ~clk;

   hit_event_manager #(
      .START_LIVES  (START_LIVES),
      .INVULN_FRAMES(INVULN_FRAMES)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .bubbleHitChar (bubbleHitChar),
      .arrowHitBubble(arrowHitBubble),
      .pixelX        (pixelX),
      .pixelY        (pixelY),
      .charHitPulse  (charHitPulse),
      .arrowReset    (arrowReset),
      .livesLeft     (livesLeft),
      .invulnerable  (invulnerable),
      .gameOver      (gameOver),
      .split_if      (split_if.master)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: frame contents, game bookkeeping and the pending request.
   bit m_frame_char;
   int m_frame_hx[$];
   int m_frame_hy[$];
   int m_lives, m_inv_frames_left;
   bit m_over, m_req, m_pulse, m_retract;
   int m_sx, m_sy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_frame_char = 0;
      m_frame_hx.delete();
      m_frame_hy.delete();
      m_lives = START_LIVES;
      m_inv_frames_left = 0;
      m_over = 0;
      m_req = 0;
      m_pulse = 0;
      m_retract = 0;
      m_sx = 0;
      m_sy = 0;
   endtask

   // One clock edge seen by the model, using the inputs present at that edge.
   task automatic model_clock();
      bit was_req, was_over;
      was_req   = m_req;
      was_over  = m_over;
      m_pulse   = 0;
      m_retract = 0;
      if (m_req && split_if.splitAck) m_req = 0;
      if (startOfFrame) begin
         if (m_frame_char && m_inv_frames_left == 0 && !was_over && m_lives > 0) begin
            m_lives--;
            m_pulse = 1;
            m_inv_frames_left = INVULN_FRAMES;
            if (m_lives == 0) m_over = 1;
         end else if (m_inv_frames_left > 0) begin
            m_inv_frames_left--;
         end
         if (m_frame_hx.size() > 0 && !was_over) begin
            m_retract = 1;
            if (!was_req) begin
               m_req = 1;
               m_sx = m_frame_hx[0];
               m_sy = m_frame_hy[0];
            end
         end
         m_frame_char = 0;
         m_frame_hx.delete();
         m_frame_hy.delete();
      end
      if (bubbleHitChar) m_frame_char = 1;
      if (arrowHitBubble) begin
         m_frame_hx.push_back(int'(pixelX));
         m_frame_hy.push_back(int'(pixelY));
      end
   endtask

   task automatic compare_all();
      check("lives", 32'(livesLeft), 32'(m_lives));
      check("char_pulse", 32'(charHitPulse), 32'(m_pulse));
      check("arrow_reset", 32'(arrowReset), 32'(m_retract));
      check("invulnerable", 32'(invulnerable), 32'(m_inv_frames_left != 0));
      check("game_over", 32'(gameOver), 32'(m_over));
      check("split_req", 32'(split_if.splitReq), 32'(m_req));
      check("split_x", 32'(split_if.splitX), 32'(m_sx));
      check("split_y", 32'(split_if.splitY), 32'(m_sy));
   endtask

   // Drive one cycle of inputs, clock it, then compare #1 after the edge.
   task automatic step(input bit sof, input bit bh, input bit ah,
                       input int px, input int py, input bit ack);
      startOfFrame     = sof;
      bubbleHitChar    = bh;
      arrowHitBubble   = ah;
      pixelX           = 11'(px);
      pixelY           = 11'(py);
      split_if.splitAck = ack;
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear before any edge.
   task automatic apply_reset();
      #2;
      resetN = 1'b0;
      #1;
      check("rst_lives", 32'(livesLeft), START_LIVES);
      check("rst_char_pulse", 32'(charHitPulse), 0);
      check("rst_arrow_reset", 32'(arrowReset), 0);
      check("rst_invulnerable", 32'(invulnerable), 0);
      check("rst_game_over", 32'(gameOver), 0);
      check("rst_split_req", 32'(split_if.splitReq), 0);
      check("rst_split_x", 32'(split_if.splitX), 0);
      check("rst_split_y", 32'(split_if.splitY), 0);
      model_reset();
      startOfFrame = 0;
      bubbleHitChar = 0;
      arrowHitBubble = 0;
      split_if.splitAck = 0;
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      idle();
   endtask

   initial begin
      int inv_count;
      int lost_frames[$];
      model_reset();
      split_if.splitAck = 0;
      #12;
      apply_reset();

      // Char hit held for 5 cycles, then commit; count invulnerable frames.
      repeat (5) step(0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("d1_pulse", 32'(charHitPulse), 1);
      check("d1_lives", 32'(livesLeft), 2);
      idle();
      check("d1_pulse_once", 32'(charHitPulse), 0);
      inv_count = 0;
      for (int f = 0; f < 70; f++) begin
         if (invulnerable) inv_count++;
         step(1, 0, 0, 0, 0, 0);
         idle();
      end
      check("d1_inv_frames", inv_count, INVULN_FRAMES);

      // Char hit in every frame: lives lost only at frames 1, 62, 123.
      apply_reset();
      for (int f = 1; f <= 130; f++) begin
         step(0, 1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, 0);
         if (charHitPulse) lost_frames.push_back(f);
      end
      check("d2_loss_count", lost_frames.size(), 3);
      if (lost_frames.size() == 3) begin
         check("d2_loss_1", lost_frames[0], 1);
         check("d2_loss_2", lost_frames[1], 62);
         check("d2_loss_3", lost_frames[2], 123);
      end
      check("d2_game_over", 32'(gameOver), 1);
      check("d2_lives_zero", 32'(livesLeft), 0);

      // Two arrow hits in one frame; the first coordinates win.
      apply_reset();
      step(0, 0, 1, 100, 50, 0);
      step(0, 0, 1, 200, 60, 0);
      step(1, 0, 0, 0, 0, 0);
      check("d3_req", 32'(split_if.splitReq), 1);
      check("d3_x", 32'(split_if.splitX), 100);
      check("d3_y", 32'(split_if.splitY), 50);
      check("d3_retract", 32'(arrowReset), 1);
      idle();
      check("d3_retract_once", 32'(arrowReset), 0);
      // Second arrow commit while pending: retract only, coordinates unchanged.
      step(0, 0, 1, 300, 70, 0);
      step(1, 0, 0, 0, 0, 0);
      check("d4_retract", 32'(arrowReset), 1);
      check("d4_x_kept", 32'(split_if.splitX), 100);
      check("d4_y_kept", 32'(split_if.splitY), 50);
      step(0, 0, 0, 0, 0, 1);
      check("d3_req_dropped", 32'(split_if.splitReq), 0);
      step(1, 0, 0, 0, 0, 0);
      idle();
      check("d4_no_second_req", 32'(split_if.splitReq), 0);

      // Hit coincident with startOfFrame belongs to the new frame.
      apply_reset();
      step(1, 1, 0, 0, 0, 0);
      check("d5_not_now", 32'(charHitPulse), 0);
      check("d5_lives_kept", 32'(livesLeft), 3);
      idle();
      step(1, 0, 0, 0, 0, 0);
      check("d5_next_frame", 32'(charHitPulse), 1);
      check("d5_lives_dec", 32'(livesLeft), 2);

      // Reset while a request is pending and the counter sits at 30.
      apply_reset();
      step(0, 1, 1, 7, 9, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int f = 0; f < 30; f++) begin
         idle();
         step(1, 0, 0, 0, 0, 0);
      end
      check("d6_req_pending", 32'(split_if.splitReq), 1);
      check("d6_invulnerable", 32'(invulnerable), 1);
      apply_reset();

      // Randomized traffic, including back-to-back frames and stray acks.
      for (int n = 0; n < 3000; n++) begin
         bit sof, bh, ah, ack;
         if (n == 1600) apply_reset();
         sof = ($urandom_range(0, 4) == 0);
         bh  = ($urandom_range(0, 9) == 0);
         ah  = ($urandom_range(0, 7) == 0);
         ack = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         step(sof, bh, ah, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)), ack);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
